// File: rtl/mmio_seg_panel_if.sv
// Data-memory bus slice seen by the front-panel peripheral.
interface mmio_seg_panel_if #(
  parameter int WIDTH = 32
);
  logic             sel;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (output sel, memwrite, adr, writedata, input readdata);
  modport slave  (input sel, memwrite, adr, writedata, output readdata);
endinterface

// File: rtl/mmio_seg_panel.sv
// Front panel: multiplexed active-low 7-segment display plus debounced buttons with sticky press events.
// Build option DEBOUNCE_EN compiles in the counter debouncer; without it the synchronised level is taken directly.
module mmio_seg_panel #(
  parameter int WIDTH     = 32,
  parameter int DIGITS    = 4,
  parameter int BUTTONS   = 2,
  parameter int DEBOUNCE  = 16,
  parameter int SCAN_BITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  mmio_seg_panel_if.slave    bus,
  input  logic [BUTTONS-1:0] btn,
  output logic [DIGITS-1:0]  AN,
  output logic [7:0]         CX
);

  localparam logic [2:0] IDX_LAST = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0]  data_q, data_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic [DIGITS-1:0]    dp_q, dp_d;
  logic [BUTTONS-1:0]   event_q, event_d;
  logic [BUTTONS-1:0]   sync1_q, sync2_q;
  logic [BUTTONS-1:0]   stable_q, stable_d;
  logic [WIDTH-1:0]     readdata_q, readdata_d;
  logic [SCAN_BITS-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [7:0]           cx_q, cx_d;

  logic                 wr, rd;
  logic [31:0]          data_pad;
  logic [7:0]           blank_pad, dp_pad;
  logic [3:0]           nib;
  logic [BUTTONS-1:0]   rise;
  logic                 unused_bits;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign wr = bus.sel & bus.memwrite;
  assign rd = bus.sel & ~bus.memwrite;

  assign unused_bits = ^{bus.adr, bus.writedata};

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE);

  logic [CW-1:0] cnt_q [BUTTONS];
  logic [CW-1:0] cnt_d [BUTTONS];

  // Any return to agreement restarts the count, so short glitches never promote.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE - 1)) stable_d[i] = sync2_q[i];
        else                               cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = ^32'(DEBOUNCE);
  assign stable_d        = sync2_q;
`endif

  assign rise = stable_d & ~stable_q;

  always_comb begin
    data_d     = data_q;
    blank_d    = blank_q;
    dp_d       = dp_q;
    event_d    = event_q;
    readdata_d = readdata_q;

    if (wr) begin
      case (bus.adr[3:2])
        2'd0: data_d = bus.writedata[4*DIGITS-1:0];
        2'd1: begin
          blank_d = bus.writedata[DIGITS-1:0];
          dp_d    = bus.writedata[8+DIGITS-1:8];
        end
        2'd3:    event_d = event_q & ~bus.writedata[BUTTONS-1:0];
        default: ;
      endcase
    end
    // A press accepted on the clearing edge must not be lost.
    event_d = event_d | rise;

    if (rd) begin
      case (bus.adr[3:2])
        2'd0:    readdata_d = WIDTH'(data_q);
        2'd1:    readdata_d = WIDTH'({dp_q, blank_pad});
        2'd2:    readdata_d = WIDTH'(stable_q);
        default: readdata_d = WIDTH'(event_q);
      endcase
    end
  end

  always_comb begin
    data_pad   = 32'(data_q);
    blank_pad  = 8'(blank_q);
    dp_pad     = 8'(dp_q);
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (&scan_cnt_q) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    // Outputs are registered against the next index so AN and CX switch together.
    nib  = data_pad[{idx_d, 2'b00} +: 4];
    an_d = ~(DIGITS'(1) << idx_d);
    cx_d = blank_pad[idx_d] ? 8'hFF : ~{dp_pad[idx_d], hex7(nib)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      blank_q    <= '0;
      dp_q       <= '0;
      event_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      readdata_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      cx_q       <= 8'hFF;
    end else begin
      data_q     <= data_d;
      blank_q    <= blank_d;
      dp_q       <= dp_d;
      event_q    <= event_d;
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      readdata_q <= readdata_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      cx_q       <= cx_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign AN           = an_q;
  assign CX           = cx_q;

endmodule

// File: doc/mmio_seg_panel.md
# mmio_seg_panel

Memory-mapped front-panel peripheral on the data-memory bus of the MIPS core. It drives a multiplexed active-low 7-segment display with DIGITS digits and takes BUTTONS push-button inputs through synchronisers and debouncers. It latches press events in sticky registers that software clears by writing 1 to the bit. It generalises the fixed 4-digit / up-down-button panel to a parametrised digit count, button count, blanking, decimal points and event capture.

## Interface
- WIDTH, 32, bus data/address width
- DIGITS, 4, number of display digits, 1..8
- BUTTONS, 2, number of button inputs, 1..8
- DEBOUNCE, 16, consecutive stable cycles required before a button level is accepted, ≥2
- SCAN_BITS, 16, refresh divider width; the active digit advances every 2^SCAN_BITS cycles
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- sel  input  1  bus select for this peripheral, decoded externally
- memwrite  input  1  write strobe, qualified by sel
- adr  input  WIDTH  byte address; only adr[3:2] is decoded
- writedata  input  WIDTH  write data
- readdata  output  WIDTH  registered read data
- btn  input  BUTTONS  raw asynchronous buttons, active-high
- AN  output  DIGITS  digit enables, active-low, one-hot-low
- CX  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Register map by adr[3:2]:
  - 0 DATA: 4 bits per digit; digit i = [4i+3:4i]; R/W; unused bits read 0.
  - 1 CTRL: [DIGITS-1:0] blank mask (1 = digit dark); [8+DIGITS-1:8] decimal points (1 = lit); R/W.
  - 2 LEVEL: [BUTTONS-1:0] debounced levels; RO, writes ignored.
  - 3 EVENT: [BUTTONS-1:0] sticky press flags; write 1 clears a bit, write 0 leaves it.
- Write: when sel & memwrite, the register updates on that clk edge.
- Read: when sel & !memwrite, readdata <= the selected register zero-extended, on the same edge. Otherwise readdata holds its value.
- Scan: a SCAN_BITS counter free-runs. On wrap, the digit index advances 0,1,…,DIGITS-1,0.
  - AN[idx]=0 and all other AN bits are 1.
  - CX is the hex decode (0-F, standard segments) of DATA digit idx, with dp from CTRL. Both are inverted to active-low.
  - A blanked digit drives CX=8'hFF with AN still cycling.
- Buttons: each bit passes through a 2-flop synchroniser, then a per-button counter.
  - The counter increments while sync ≠ stable and clears when they match.
  - When it reaches DEBOUNCE-1 on a mismatch cycle: stable <= sync and counter clears.
- Event: the EVENT bit sets on the edge where stable goes 0→1. Release does not set an event.
- Simultaneous set and write-1-clear of the same bit: set wins, bit reads 1.
- Reset values (async, while reset=0):
  - DATA=0, CTRL=0, LEVEL=0, EVENT=0, readdata=0.
  - Counters and synchronisers 0, digit index 0.
  - AN all 1s, CX=8'hFF.
  - First AN assertion (AN[0]=0) occurs on the first edge after release.

## Timing
- Write-to-display: CX reflects new DATA/CTRL on the edge after the write, if that digit is active.
- Read latency: 1 cycle. readdata is valid after the edge that samples sel.
- Button latency, with DEBOUNCE_EN: stable and EVENT change on the (DEBOUNCE+2)th rising edge after btn changes and holds.
- Any glitch shorter than DEBOUNCE cycles (after synchronisation) is rejected.
- Digit period: 2^SCAN_BITS cycles. Full refresh: DIGITS·2^SCAN_BITS cycles. Index wraps from DIGITS-1 to 0.
- Reset asserted mid-scan or mid-debounce returns all state to reset values immediately, without waiting for clk.

## Configuration
- DEBOUNCE_EN defined: the counter-based debouncer is compiled in as described.
- DEBOUNCE_EN undefined: the debounce counters are removed. stable <= sync every cycle, so LEVEL/EVENT change on the 3rd edge after btn changes and glitches are not filtered. The DEBOUNCE parameter is ignored.

## Test plan
- Reset: hold reset=0 with btn toggling → AN all 1s, CX=8'hFF, readdata=0. After release, AN[0]=0 on the first edge.
- Display, DIGITS=4, SCAN_BITS=2: write DATA=32'h0000_A3F1, CTRL=0 → scan shows digit0 CX=8'hF9 ('1'), digit1 8'h8E ('F'), digit2 8'hB0 ('3'), digit3 8'h88 ('A'), 4 cycles each, then wraps.
- Blank/dp: CTRL=32'h0000_0102 → digit1 CX=8'hFF, digit0 dp low (CX=8'h79).
- Debounce, DEBOUNCE=16: btn[0] high for 10 cycles then low → LEVEL=0, EVENT=0. Held high → LEVEL[0]=1 and EVENT[0]=1 on edge 18.
- Clear race: write EVENT=1 on the same edge a new btn[1] press is accepted → EVENT[1] reads 1. A later write-1 with no press → reads 0.
- Without DEBOUNCE_EN: 1-cycle-wide (post-sync) pulse on btn[0] → EVENT[0]=1 on edge 3.
